// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and constants for the UART transmit serializer.
// Optional parity support is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

    localparam logic UART_IDLE_LVL = 1'b1;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        HOLD
    } tx_state_t;
`else
    localparam int unsigned PARITY_BITS = 0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        HOLD
    } tx_state_t;
`endif

    // Bit periods occupied by one frame: start + data + optional parity + stop.
    function automatic int unsigned frame_ticks(input int unsigned data_bits,
                                                input int unsigned stop_bits);
        return 1 + data_bits + PARITY_BITS + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the upstream sequencer (master) and the serializer (slave).
interface uart_tx_serializer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a byte over valid/ready and shifts it out LSB first,
// one symbol per baud_tick, on a registered idle-high txd line.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    uart_tx_serializer_if.slave tx_if,
    output logic              txd,
    output logic              tx_busy
);

    localparam int unsigned CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1)
    begin : g_bad_cfg
        $error("uart_tx_serializer: illegal parameter combination");
    end

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [CW-1:0]        bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 txd_n;
    logic                 ready_q;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_n;
`endif

    assign tx_if.tx_ready = ready_q;

    // Next-state and next-output logic; every symbol change waits for baud_tick.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        txd_n      = txd;
`ifdef UART_TX_PARITY_EN
        par_n      = par_q;
`endif
        case (state)
            IDLE: begin
                txd_n = UART_IDLE_LVL;
                if (tx_if.tx_valid) begin
                    shreg_n = tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
                    par_n   = (^tx_if.tx_data) ^ 1'(PARITY_ODD);
`endif
                    state_n = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    txd_n     = 1'b0;
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    txd_n   = shreg[0];
                    shreg_n = shreg >> 1;
                    // Counter holds on the last bit rather than wrapping.
                    if (bit_cnt == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    txd_n   = par_q;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    txd_n      = UART_IDLE_LVL;
                    stop_cnt_n = 1'b0;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (baud_tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        state_n = IDLE;
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = UART_IDLE_LVL;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd      <= UART_IDLE_LVL;
            ready_q  <= 1'b1;
            tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            txd      <= txd_n;
            ready_q  <= (state_n == IDLE);
            tx_busy  <= (state_n != IDLE);
`ifdef UART_TX_PARITY_EN
            par_q    <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: two serializers (1 stop bit even parity, 2 stop bits odd parity)
// compared every cycle against a bit-period reference model.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    logic clk;
    logic rst;
    logic baud_tick;
    logic txd0, busy0, txd1, busy1;

    uart_tx_serializer_if #(.DATA_BITS(8)) if0 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) if1 ();

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_if(if0.slave),
        .txd(txd0), .tx_busy(busy0)
    );

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_if(if1.slave),
        .txd(txd1), .tx_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per DUT, the queue of line levels still to be emitted,
    // one entry per bit period after the start tick.
    logic m_ready [2];
    logic m_busy  [2];
    logic m_txd   [2];
    int   acc     [2];
    logic q0 [$];
    logic q1 [$];

    int n_checks;
    int n_pass;
    int tick_div;

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    function automatic void push_sym(input int k, input logic s);
        if (k == 0) q0.push_back(s);
        else        q1.push_back(s);
    endfunction

    function automatic void load_frame(input int k, input logic [7:0] d);
        int unsigned stops = (k == 0) ? 1 : 2;
        push_sym(k, 1'b0);
        for (int i = 0; i < 8; i++) push_sym(k, d[i]);
`ifdef UART_TX_PARITY_EN
        // Even parity makes the total count of ones even; odd inverts that.
        push_sym(k, logic'(($countones(d) % 2) == 1) ^ logic'(k == 1));
`endif
        for (int unsigned i = 0; i < stops; i++) push_sym(k, 1'b1);
    endfunction

    function automatic void model_step(input int k);
        logic       v;
        logic [7:0] d;
        int         qs;
        v  = (k == 0) ? if0.tx_valid : if1.tx_valid;
        d  = (k == 0) ? if0.tx_data  : if1.tx_data;
        qs = (k == 0) ? q0.size() : q1.size();
        if (rst) begin
            m_ready[k] = 1'b1;
            m_busy[k]  = 1'b0;
            m_txd[k]   = 1'b1;
            if (k == 0) q0.delete(); else q1.delete();
        end else if (m_ready[k]) begin
            if (v) begin
                m_ready[k] = 1'b0;
                m_busy[k]  = 1'b1;
                acc[k]++;
                load_frame(k, d);
            end
        end else if (baud_tick) begin
            if (qs > 0) begin
                m_txd[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
            end else begin
                // The tick that closes the last stop period returns the line to idle.
                m_ready[k] = 1'b1;
                m_busy[k]  = 1'b0;
            end
        end
    endfunction

    // One clock: DUTs and model advance on the edge, outputs compared at negedge,
    // then the baud strobe for the following edge is set up.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        model_step(0);
        model_step(1);
        chk("txd0",   txd0,         m_txd[0]);
        chk("ready0", if0.tx_ready, m_ready[0]);
        chk("busy0",  busy0,        m_busy[0]);
        chk("txd1",   txd1,         m_txd[1]);
        chk("ready1", if1.tx_ready, m_ready[1]);
        chk("busy1",  busy1,        m_busy[1]);
        tick_div  = (tick_div == 15) ? 0 : tick_div + 1;
        baud_tick = (tick_div == 15);
    endtask

    task automatic set_valid(input int k, input logic v, input logic [7:0] d);
        if (k == 0) begin if0.tx_valid = v; if0.tx_data = d; end
        else        begin if1.tx_valid = v; if1.tx_data = d; end
    endtask

    task automatic wait_accept(input int k, input string tag);
        int start_acc = acc[k];
        int n = 0;
        while (acc[k] == start_acc && n < 16 * 32) begin
            cycle();
            n++;
        end
        if (acc[k] == start_acc) timeout_fail(tag);
    endtask

    task automatic send(input int k, input logic [7:0] d);
        set_valid(k, 1'b1, d);
        wait_accept(k, "accept");
        set_valid(k, 1'b0, 8'h00);
    endtask

    task automatic wait_idle(input int k);
        int unsigned bound = 16 * (frame_ticks(8, 2) + 4);
        int unsigned n = 0;
        while (!m_ready[k] && n < bound) begin
            cycle();
            n++;
        end
        if (!m_ready[k]) timeout_fail("idle");
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        tick_div = 0;
        for (int k = 0; k < 2; k++) begin
            m_ready[k] = 1'b1;
            m_busy[k]  = 1'b0;
            m_txd[k]   = 1'b1;
            acc[k]     = 0;
        end
        rst          = 1'b1;
        baud_tick    = 1'b0;
        if0.tx_valid = 1'b0;
        if0.tx_data  = 8'h00;
        if1.tx_valid = 1'b0;
        if1.tx_data  = 8'h00;

        // Reset state.
        repeat (3) cycle();
        rst = 1'b0;
        repeat (5) cycle();

        // 0x55 on the 1-stop DUT.
        send(0, 8'h55);
        wait_idle(0);

        // 0xA3: parity bit present only when the feature is built in.
        send(0, 8'hA3);
        wait_idle(0);

        // Back-to-back with tx_valid held across both accepts.
        set_valid(0, 1'b1, 8'h01);
        wait_accept(0, "b2b_first");
        set_valid(0, 1'b1, 8'h80);
        wait_accept(0, "b2b_second");
        set_valid(0, 1'b0, 8'h00);
        wait_idle(0);

        // Accept coincident with baud_tick: that tick must not start the frame.
        begin
            int n = 0;
            while (!(baud_tick && m_ready[0]) && n < 40) begin
                cycle();
                n++;
            end
            if (!(baud_tick && m_ready[0])) timeout_fail("tick_align");
            set_valid(0, 1'b1, 8'hC6);
            cycle();
            set_valid(0, 1'b0, 8'h00);
            wait_idle(0);
        end

        // 2-stop DUT with 0xFF; valid pulses while busy must be ignored.
        send(1, 8'hFF);
        for (int p = 0; p < 4; p++) begin
            repeat (20) cycle();
            set_valid(1, 1'b1, 8'h5A);
            cycle();
            set_valid(1, 1'b0, 8'h00);
        end
        wait_idle(1);

        // Reset held 3 clocks in the middle of frames on both DUTs, then a clean frame.
        set_valid(0, 1'b1, 8'h96);
        set_valid(1, 1'b1, 8'h69);
        cycle();
        set_valid(0, 1'b0, 8'h00);
        set_valid(1, 1'b0, 8'h00);
        repeat (70) cycle();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        send(0, 8'h3C);
        send(1, 8'hC3);
        wait_idle(0);
        wait_idle(1);

        // Randomized frames with random gaps and stray valid pulses while busy.
        for (int unsigned it = 0; it < 16; it++) begin
            int         k;
            logic [7:0] d;
            k = int'($urandom_range(0, 1));
            d = 8'($urandom);
            repeat ($urandom_range(0, 20)) cycle();
            send(k, d);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 40)) cycle();
                if (!m_ready[k]) begin
                    set_valid(k, 1'b1, 8'($urandom));
                    cycle();
                    set_valid(k, 1'b0, 8'h00);
                end
            end
            wait_idle(k);
        end

        repeat (4) cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
